// File: rtl/sort_pkg.sv
// Shared types for the odd-even transposition block sorter.
// Holds the FSM state enum, the CAS latency and the tagged pair bundle.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        DRAIN,
        UNLOAD
    } state_t;

    localparam int CAS_LAT = 2;

    // Pair bundle field widths; the sorter WIDTH must not exceed PAIR_DW
    // and N must not exceed 2**PAIR_TW.
    localparam int PAIR_DW = 32;
    localparam int PAIR_TW = 8;

    typedef struct packed {
        logic                      valid;
        logic [PAIR_TW-1:0]        idx;
        logic signed [PAIR_DW-1:0] a;
        logic signed [PAIR_DW-1:0] b;
    } pair_t;

endpackage

// File: rtl/sort_cas_stage.sv
// Two-stage pipelined signed compare-and-swap unit.
// Ports: clk, rst (async active-high), in_pair (a,b,tag), out_pair (a=min, b=max, tag).
module sort_cas_stage
    import sort_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  pair_t in_pair,
    output pair_t out_pair
);

    pair_t s1;
    logic  s1_swap;

    // Stage 1: operands, tag and the compare flag. Ties do not swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s1_swap <= 1'b0;
        end else begin
            s1      <= in_pair;
            s1_swap <= (in_pair.a > in_pair.b);
        end
    end

    // Stage 2: ordered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pair <= '0;
        end else begin
            out_pair.valid <= s1.valid;
            out_pair.idx   <= s1.idx;
            out_pair.a     <= s1_swap ? s1.b : s1.a;
            out_pair.b     <= s1_swap ? s1.a : s1.b;
        end
    end

endmodule

// File: rtl/sort_oets_ctrl.sv
// Block sorter: loads N signed words, sorts them by odd-even transposition
// through one shared pipelined CAS unit, then streams them out ascending.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data stream in;
// out_valid/out_ready/out_data/out_last stream out; busy during ISSUE/DRAIN.
module sort_oets_ctrl
    import sort_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;

    state_t state, state_nx;

    logic [IW-1:0] ld_idx;
    logic [IW-1:0] un_idx;
    logic [IW-1:0] pair;
    logic [IW-1:0] dr_cnt;
    logic [PW-1:0] phase;

    logic signed [WIDTH-1:0] bank [N];

    logic [IW-1:0] j;
    logic [IW-1:0] wj;
    logic          last_pair;
    logic          last_phase;
    logic          drain_done;
    logic          last_word;

    pair_t iss;
    pair_t wb;
    logic  unused_wb;

    // Lower index of the pair: 2*pair on even phases, 2*pair+1 on odd ones.
    assign j          = {pair[IW-2:0], phase[0]};
    assign wj         = wb.idx[IW-1:0];
    assign last_pair  = (pair == (phase[0] ? IW'(N/2-2) : IW'(N/2-1)));
    assign last_phase = (phase == PW'(N-1));
    assign drain_done = (dr_cnt == IW'(CAS_LAT-1));
    assign last_word  = (un_idx == IW'(N-1));
    assign unused_wb  = ^{wb.idx, wb.a, wb.b};

    sort_cas_stage u_cas (
        .clk      (clk),
        .rst      (rst),
        .in_pair  (iss),
        .out_pair (wb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        iss       = '0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && ld_idx == IW'(N-1)) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                iss.valid = 1'b1;
                iss.idx   = PAIR_TW'(j);
                iss.a     = PAIR_DW'(bank[j]);
                iss.b     = PAIR_DW'(bank[j + IW'(1)]);
                if (last_pair) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_nx = last_phase ? UNLOAD : ISSUE;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = bank[un_idx];
                out_last  = last_word;
                if (out_ready && last_word) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_idx <= '0;
            un_idx <= '0;
            pair   <= '0;
            dr_cnt <= '0;
            phase  <= '0;
            for (int i = 0; i < N; i++) begin
                bank[i] <= '0;
            end
        end else begin
            // Writebacks only land during ISSUE/DRAIN, never with a load.
            if (wb.valid) begin
                bank[wj]           <= wb.a[WIDTH-1:0];
                bank[wj + IW'(1)]  <= wb.b[WIDTH-1:0];
            end
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        bank[ld_idx] <= in_data;
                        if (ld_idx == IW'(N-1)) begin
                            ld_idx <= '0;
                            phase  <= '0;
                            pair   <= '0;
                        end else begin
                            ld_idx <= ld_idx + IW'(1);
                        end
                    end
                end
                ISSUE: begin
                    pair   <= last_pair ? '0 : pair + IW'(1);
                    dr_cnt <= '0;
                end
                DRAIN: begin
                    if (drain_done) begin
                        dr_cnt <= '0;
                        phase  <= last_phase ? '0 : phase + PW'(1);
                        un_idx <= '0;
                    end else begin
                        dr_cnt <= dr_cnt + IW'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        un_idx <= last_word ? '0 : un_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
